// File: rtl/taxi_pkg.sv
// Shared types and fare constants for the taxi meter trip controller.
package taxi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HLD  = 2'd2,
    ST_DONE = 2'd3
  } taxi_state_e;

  localparam int W_DEF     = 16;
  localparam int BASE      = 5;
  localparam int FREE_DIST = 3;
  localparam int RATE_DIST = 2;
  localparam int OFFSET    = 1;

endpackage

// File: rtl/taxi_fare_calc.sv
// Combinational fare function of distance and minutes, saturated to W bits.
module taxi_fare_calc
  import taxi_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] distance,
  input  logic [W-1:0] minute,
  output logic [W-1:0] fare
);

  // Two extra bits hold minute + 2*distance without overflow.
  localparam int FW = W + 2;

  logic [FW-1:0] dist_ext;
  logic [FW-1:0] min_ext;
  logic [FW-1:0] raw;

  always_comb begin
    dist_ext = FW'(distance);
    min_ext  = FW'(minute);
    if (distance < W'(FREE_DIST)) begin
      raw = min_ext + FW'(BASE);
    end else begin
      raw = min_ext + (FW'(RATE_DIST) * dist_ext) - FW'(OFFSET);
    end
    if (|raw[FW-1:W]) begin
      fare = '1;
    end else begin
      fare = raw[W-1:0];
    end
  end

endmodule

// File: rtl/taxi_meter_ctrl.sv
// Taxi trip controller: trip FSM, edge detectors, minute prescaler,
// saturating distance/minute counters and a registered fare.
module taxi_meter_ctrl
  import taxi_pkg::*;
#(
  parameter int TICKS_PER_MIN = 60,
  parameter int W             = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic         hold,
  input  logic         clear,
  input  logic         wheel,
  input  logic         tick,
  output logic [W-1:0] distance,
  output logic [W-1:0] minute,
  output logic [W-1:0] fare,
  output logic         fare_valid,
  output logic         busy,
  output logic [1:0]   state
);

  localparam int PW = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICKS_PER_MIN - 1);

  taxi_state_e   state_q, state_d;
  logic [W-1:0]  dist_q, dist_d;
  logic [W-1:0]  min_q, min_d;
  logic [W-1:0]  fare_q, fare_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          fare_valid_q, fare_valid_d;
  logic          busy_q, busy_d;
  logic          start_q, stop_q, clear_q, wheel_q;

  logic          start_rise, stop_rise, clear_rise, wheel_rise;
  logic          count_en;
  logic [W-1:0]  fare_calc;

  taxi_fare_calc #(.W(W)) u_fare (
    .distance (dist_q),
    .minute   (min_q),
    .fare     (fare_calc)
  );

  always_comb begin
    start_rise = start & ~start_q;
    stop_rise  = stop  & ~stop_q;
    clear_rise = clear & ~clear_q;
    wheel_rise = wheel & ~wheel_q;
  end

  always_comb begin
    state_d  = state_q;
    dist_d   = dist_q;
    min_d    = min_q;
    presc_d  = presc_q;
    count_en = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          state_d = ST_RUN;
          dist_d  = '0;
          min_d   = '0;
          presc_d = '0;
        end
      end
      ST_RUN: begin
        // Stop beats hold, and events in the stop cycle still count.
        if (stop_rise) begin
          state_d  = ST_DONE;
          count_en = 1'b1;
        end else if (hold) begin
          state_d = ST_HLD;
        end else begin
          count_en = 1'b1;
        end
      end
      ST_HLD: begin
        if (stop_rise) begin
          state_d = ST_DONE;
        end else if (!hold) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (clear_rise) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (count_en) begin
      if (wheel_rise && (dist_q != '1)) begin
        dist_d = dist_q + W'(1);
      end
      if (tick) begin
        if (presc_q == PMAX) begin
          presc_d = '0;
          if (min_q != '1) begin
            min_d = min_q + W'(1);
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
    end

    busy_d       = (state_d == ST_RUN) || (state_d == ST_HLD);
    // One cycle behind DONE entry so the fare register has caught up.
    fare_valid_d = (state_q == ST_DONE) && (state_d == ST_DONE);
    fare_d       = fare_calc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      dist_q       <= '0;
      min_q        <= '0;
      fare_q       <= '0;
      presc_q      <= '0;
      fare_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      start_q      <= 1'b0;
      stop_q       <= 1'b0;
      clear_q      <= 1'b0;
      wheel_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      dist_q       <= dist_d;
      min_q        <= min_d;
      fare_q       <= fare_d;
      presc_q      <= presc_d;
      fare_valid_q <= fare_valid_d;
      busy_q       <= busy_d;
      start_q      <= start;
      stop_q       <= stop;
      clear_q      <= clear;
      wheel_q      <= wheel;
    end
  end

  always_comb begin
    distance   = dist_q;
    minute     = min_q;
    fare       = fare_q;
    fare_valid = fare_valid_q;
    busy       = busy_q;
    state      = state_q;
  end

endmodule

// File: tb/tb_taxi_meter_ctrl.sv
// Directed bench for taxi_meter_ctrl with an expected-value queue; a narrow
// second instance covers counter and fare saturation.
module tb_taxi_meter_ctrl;

  localparam int W  = 16;
  localparam int SW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0, stop = 1'b0, hold = 1'b0, clear = 1'b0;
  logic          wheel = 1'b0, tick = 1'b0;

  logic [W-1:0]  distance, minute, fare;
  logic          fare_valid, busy;
  logic [1:0]    state;

  logic [SW-1:0] sat_distance, sat_minute, sat_fare;
  logic          sat_fare_valid, sat_busy;
  logic [1:0]    sat_state;

  logic [W-1:0]  exp_q[$];
  string         tag_q[$];
  int            errors = 0;
  int            checks = 0;

  taxi_meter_ctrl #(.TICKS_PER_MIN(4), .W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .hold(hold),
    .clear(clear), .wheel(wheel), .tick(tick),
    .distance(distance), .minute(minute), .fare(fare),
    .fare_valid(fare_valid), .busy(busy), .state(state)
  );

  taxi_meter_ctrl #(.TICKS_PER_MIN(4), .W(SW)) sat_dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .hold(hold),
    .clear(clear), .wheel(wheel), .tick(tick),
    .distance(sat_distance), .minute(sat_minute), .fare(sat_fare),
    .fare_valid(sat_fare_valid), .busy(sat_busy), .state(sat_state)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input string t, input logic [W-1:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  task automatic check_v(input logic [W-1:0] obs);
    logic [W-1:0] e;
    string        t;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(1); start = 1'b0; cyc(1);
  endtask

  task automatic pulse_clear();
    clear = 1'b1; cyc(1); clear = 1'b0; cyc(1);
  endtask

  task automatic wheel_rises(input int n);
    for (int i = 0; i < n; i++) begin
      wheel = 1'b1; cyc(1); wheel = 1'b0; cyc(1);
    end
  endtask

  task automatic ticks(input int n);
    tick = 1'b1; cyc(n); tick = 1'b0;
  endtask

  // Queues the expected settled trip, raises stop, then compares after the
  // two-cycle settle.
  task automatic stop_and_settle(input string t, input logic [W-1:0] d,
                                 input logic [W-1:0] m, input logic [W-1:0] f);
    expect_v({t, "_state_at_stop"}, 16'd3);
    expect_v({t, "_valid_at_stop"}, 16'd0);
    expect_v({t, "_distance"}, d);
    expect_v({t, "_minute"}, m);
    expect_v({t, "_fare"}, f);
    expect_v({t, "_fare_valid"}, 16'd1);
    expect_v({t, "_busy"}, 16'd0);
    stop = 1'b1; cyc(1);
    check_v(16'(state));
    check_v(16'(fare_valid));
    stop = 1'b0; cyc(1);
    check_v(distance);
    check_v(minute);
    check_v(fare);
    check_v(16'(fare_valid));
    check_v(16'(busy));
  endtask

  initial begin
    // Reset values while reset is held.
    #1 rst = 1'b1;
    #2;
    expect_v("rst_state", 16'd0);    check_v(16'(state));
    expect_v("rst_distance", 16'd0); check_v(distance);
    expect_v("rst_minute", 16'd0);   check_v(minute);
    expect_v("rst_fare", 16'd0);     check_v(fare);
    expect_v("rst_valid", 16'd0);    check_v(16'(fare_valid));
    expect_v("rst_busy", 16'd0);     check_v(16'(busy));
    cyc(2);
    rst = 1'b0;
    cyc(1);

    // Stop and clear are ignored in IDLE.
    stop = 1'b1; cyc(1); stop = 1'b0; cyc(1);
    expect_v("idle_ignore_stop", 16'd0); check_v(16'(state));

    // Short trip: 2 units, 8 ticks -> 2 minutes, fare 5+2.
    start = 1'b1; cyc(1);
    expect_v("start_state", 16'd1); check_v(16'(state));
    expect_v("start_busy", 16'd1);  check_v(16'(busy));
    start = 1'b0; cyc(1);
    wheel_rises(2);
    ticks(8);
    stop_and_settle("short", 16'd2, 16'd2, 16'd7);

    // Start in DONE is ignored; clear returns to IDLE keeping counters.
    start = 1'b1; cyc(1);
    expect_v("done_ignore_start", 16'd3); check_v(16'(state));
    start = 1'b0; cyc(1);
    clear = 1'b1; cyc(1);
    expect_v("clear_state", 16'd0);    check_v(16'(state));
    expect_v("clear_valid", 16'd0);    check_v(16'(fare_valid));
    expect_v("clear_distance", 16'd2); check_v(distance);
    clear = 1'b0; cyc(1);

    // Long trip: 10 units, 12 ticks -> 3 minutes, fare 3+20-1.
    pulse_start();
    expect_v("long_cleared_distance", 16'd0); check_v(distance);
    wheel_rises(10);
    ticks(12);
    stop_and_settle("long", 16'd10, 16'd3, 16'd22);
    pulse_clear();

    // Hold: prescaler at 2 survives HLD; events during HLD are dropped.
    pulse_start();
    ticks(2);
    hold = 1'b1; cyc(1);
    expect_v("hold_state", 16'd2); check_v(16'(state));
    expect_v("hold_busy", 16'd1);  check_v(16'(busy));
    wheel_rises(5);
    ticks(8);
    expect_v("hold_frozen_distance", 16'd0); check_v(distance);
    hold = 1'b0; cyc(1);
    expect_v("unhold_state", 16'd1); check_v(16'(state));
    ticks(2);
    wheel_rises(1);
    stop_and_settle("hold", 16'd1, 16'd1, 16'd6);
    pulse_clear();

    // Wheel rise, minute-wrapping tick and stop rise in one cycle.
    pulse_start();
    wheel_rises(3);
    ticks(3);
    wheel = 1'b1; tick = 1'b1;
    expect_v("simul_state_at_stop", 16'd3);
    expect_v("simul_distance", 16'd4);
    expect_v("simul_minute", 16'd1);
    expect_v("simul_fare", 16'd8);
    expect_v("simul_valid", 16'd1);
    stop = 1'b1; cyc(1);
    wheel = 1'b0; tick = 1'b0; stop = 1'b0;
    check_v(16'(state));
    cyc(1);
    check_v(distance);
    check_v(minute);
    check_v(fare);
    check_v(16'(fare_valid));
    pulse_clear();

    // Saturation: 66 units saturate the 6-bit instance, not the 16-bit one.
    pulse_start();
    wheel_rises(66);
    stop = 1'b1; cyc(1); stop = 1'b0; cyc(1);
    expect_v("sat_distance", 16'h3F);  check_v(16'(sat_distance));
    expect_v("sat_fare", 16'h3F);      check_v(16'(sat_fare));
    expect_v("sat_valid", 16'd1);      check_v(16'(sat_fare_valid));
    expect_v("wide_distance", 16'd66); check_v(distance);
    expect_v("wide_fare", 16'd131);    check_v(fare);
    pulse_clear();

    // Asynchronous reset in the middle of a running trip.
    pulse_start();
    wheel_rises(3);
    ticks(5);
    expect_v("pre_rst_distance", 16'd3); check_v(distance);
    rst = 1'b1;
    #2;
    expect_v("arst_state", 16'd0);    check_v(16'(state));
    expect_v("arst_distance", 16'd0); check_v(distance);
    expect_v("arst_minute", 16'd0);   check_v(minute);
    expect_v("arst_fare", 16'd0);     check_v(fare);
    expect_v("arst_busy", 16'd0);     check_v(16'(busy));
    expect_v("arst_sat_dist", 16'd0); check_v(16'(sat_distance));
    cyc(1);
    rst = 1'b0;
    cyc(2);

    if (exp_q.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
